// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//   Bundles the two writeback source handshakes, the register-file write
//   port, the hazard query/response signals and the conflict counter of
//   regfile_write_arbiter.
//   master : writeback sources / regfile / hazard logic side
//            (drives vld*, addr*, data*, a1, a2)
//   slave  : the arbiter (drives rdy*, we3, a3, wd3, pend*, conflict_cnt)
interface regfile_write_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  vld0;
    logic                  rdy0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] data0;
    logic                  vld1;
    logic                  rdy1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] data1;
    logic                  we3;
    logic [ADDR_WIDTH-1:0] a3;
    logic [DATA_WIDTH-1:0] wd3;
    logic [ADDR_WIDTH-1:0] a1;
    logic [ADDR_WIDTH-1:0] a2;
    logic                  pend1;
    logic                  pend2;
    logic [CNT_WIDTH-1:0]  conflict_cnt;

    modport master (
        output vld0, addr0, data0, vld1, addr1, data1, a1, a2,
        input  rdy0, rdy1, we3, a3, wd3, pend1, pend2, conflict_cnt
    );

    modport slave (
        input  vld0, addr0, data0, vld1, addr1, data1, a1, a2,
        output rdy0, rdy1, we3, a3, wd3, pend1, pend2, conflict_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between port 0 (ALU
//   writeback) and port 1 (multi-cycle unit). Each port has a one-entry
//   slot; writes leave oldest-first, x0 writes are swallowed, and pending
//   destinations are flagged against read addresses a1/a2.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of regfile_write_arbiter_if
//             vld/rdy/addr/data x2 in, we3/a3/wd3 out, a1/a2 in,
//             pend1/pend2 out, conflict_cnt out (saturating)
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    regfile_write_arbiter_if.slave bus
);
    logic                  full0, full1;
    logic [ADDR_WIDTH-1:0] saddr0, saddr1;
    logic [DATA_WIDTH-1:0] sdata0, sdata1;
    logic                  older;   // slot1 loaded strictly before slot0
    logic                  tie;     // both slots loaded on the same edge
    logic                  last;    // port granted most recently
    logic [CNT_WIDTH-1:0]  cnt;

    logic                  grant0, grant1;
    logic                  load0, load1;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (full0 && !full1) begin
            grant0 = 1'b1;
        end else if (full1 && !full0) begin
            grant1 = 1'b1;
        end else if (full0 && full1) begin
            if (!tie) begin
                if (older) grant1 = 1'b1;
                else       grant0 = 1'b1;
            end else if (saddr0 == saddr1) begin
                // same destination: port 1 goes first so port 0's value lands last
                grant1 = 1'b1;
            end else if (last) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        bus.rdy0 = !full0 || grant0;
        bus.rdy1 = !full1 || grant1;
        // x0 transfers complete the handshake but never occupy a slot
        load0 = bus.vld0 && bus.rdy0 && (bus.addr0 != '0);
        load1 = bus.vld1 && bus.rdy1 && (bus.addr1 != '0);

        bus.we3 = grant0 || grant1;
        bus.a3  = '0;
        bus.wd3 = '0;
        if (grant1) begin
            bus.a3  = saddr1;
            bus.wd3 = sdata1;
        end else if (grant0) begin
            bus.a3  = saddr0;
            bus.wd3 = sdata0;
        end

        bus.pend1 = (bus.a1 != '0) &&
                    ((full0 && saddr0 == bus.a1) || (full1 && saddr1 == bus.a1));
        bus.pend2 = (bus.a2 != '0) &&
                    ((full0 && saddr0 == bus.a2) || (full1 && saddr1 == bus.a2));
        bus.conflict_cnt = cnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full0  <= 1'b0;
            full1  <= 1'b0;
            saddr0 <= '0;
            saddr1 <= '0;
            sdata0 <= '0;
            sdata1 <= '0;
            older  <= 1'b0;
            tie    <= 1'b0;
            last   <= 1'b1;
            cnt    <= '0;
        end else begin
            if (load0) begin
                full0  <= 1'b1;
                saddr0 <= bus.addr0;
                sdata0 <= bus.data0;
            end else if (grant0) begin
                full0  <= 1'b0;
            end

            if (load1) begin
                full1  <= 1'b1;
                saddr1 <= bus.addr1;
                sdata1 <= bus.data1;
            end else if (grant1) begin
                full1  <= 1'b0;
            end

            if (grant0)      last <= 1'b0;
            else if (grant1) last <= 1'b1;

            // age only matters while both slots stay occupied; a lone slot's
            // stale flags are overwritten by the next load that pairs it
            if (load0 && load1) begin
                tie   <= 1'b1;
            end else if (load0 && full1 && !grant1) begin
                tie   <= 1'b0;
                older <= 1'b1;
            end else if (load1 && full0 && !grant0) begin
                tie   <= 1'b0;
                older <= 1'b0;
            end

            if (full0 && full1 && cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
        end
    end
endmodule
